// File: rtl/sdram_client_arb.sv
// Two-port round-robin arbiter with periodic auto-refresh, driving the single-command
// logic interface of the byte-addressed SDRAM controller and routing read data back.
module sdram_client_arb #(
    parameter int REFRESH_INTERVAL = 810,
    parameter int ADDR_WIDTH       = 23
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [15:0]           a_din,
    input  logic [1:0]            a_wdm,
    output logic                  a_ack,
    output logic [15:0]           a_dout,
    output logic                  a_valid,

    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [15:0]           b_din,
    input  logic [1:0]            b_wdm,
    output logic                  b_ack,
    output logic [15:0]           b_dout,
    output logic                  b_valid,

    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  mem_refresh,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_din,
    output logic [1:0]            mem_wdm,
    input  logic [15:0]           mem_dout,
    input  logic                  mem_data_ready,
    input  logic                  mem_busy
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_BUSY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] refresh_cnt;
    logic             refresh_wrap;
    logic             refresh_pending;
    logic             last_grant_b;
    logic             op_read;
    logic             op_owner_b;
    logic             grant_b;
    logic             issue;

    // Free-running interval counter; it never pauses, so refresh spacing is
    // independent of client traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
        end else if (refresh_wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign refresh_wrap = (refresh_cnt == CNT_LAST);

    // B wins when it is alone or when A had the previous grant.
    assign grant_b = b_req && (!a_req || !last_grant_b);
    assign issue   = (state == S_IDLE) && !mem_busy &&
                     (refresh_pending || a_req || b_req);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            refresh_pending <= 1'b0;
            last_grant_b    <= 1'b1;
            op_read         <= 1'b0;
            op_owner_b      <= 1'b0;
            a_ack           <= 1'b0;
            b_ack           <= 1'b0;
            a_valid         <= 1'b0;
            b_valid         <= 1'b0;
            a_dout          <= '0;
            b_dout          <= '0;
            mem_rd          <= 1'b0;
            mem_wr          <= 1'b0;
            mem_refresh     <= 1'b0;
            mem_addr        <= '0;
            mem_din         <= '0;
            mem_wdm         <= '0;
        end else begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_valid <= 1'b0;
            b_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state <= S_CMD;
                        if (refresh_pending) begin
                            mem_refresh     <= 1'b1;
                            refresh_pending <= 1'b0;
                            op_read         <= 1'b0;
                        end else if (grant_b) begin
                            mem_rd       <= ~b_wr;
                            mem_wr       <= b_wr;
                            mem_addr     <= b_addr;
                            mem_din      <= b_din;
                            mem_wdm      <= b_wdm;
                            b_ack        <= 1'b1;
                            last_grant_b <= 1'b1;
                            op_read      <= ~b_wr;
                            op_owner_b   <= 1'b1;
                        end else begin
                            mem_rd       <= ~a_wr;
                            mem_wr       <= a_wr;
                            mem_addr     <= a_addr;
                            mem_din      <= a_din;
                            mem_wdm      <= a_wdm;
                            a_ack        <= 1'b1;
                            last_grant_b <= 1'b0;
                            op_read      <= ~a_wr;
                            op_owner_b   <= 1'b0;
                        end
                    end
                end

                S_CMD: begin
                    mem_rd      <= 1'b0;
                    mem_wr      <= 1'b0;
                    mem_refresh <= 1'b0;
                    state       <= S_BUSY;
                end

                S_BUSY: begin
                    if (op_read && mem_data_ready) begin
                        if (op_owner_b) begin
                            b_dout  <= mem_dout;
                            b_valid <= 1'b1;
                        end else begin
                            a_dout  <= mem_dout;
                            a_valid <= 1'b1;
                        end
                    end
                    if (!mem_busy) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Placed after the case so a wrap in the issuing cycle re-arms the request.
            if (refresh_wrap) begin
                refresh_pending <= 1'b1;
            end
        end
    end

endmodule
